// File: rtl/mem_bus_unit.sv
// mem_bus_unit
// Multi-cycle load/store unit for the MEM stage. It takes one memory op at a
// time and runs it on a req/ack data bus. The bus may insert wait states, and
// a timeout turns into a bus error. The unit also handles byte-lane steering,
// load sign/zero extension, alignment checks and LL/SC link tracking. While
// an access is in flight, stall_req_o freezes the pipeline.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   op_valid_i      memory op present (inputs stable while stalled)
//   op_i            0 NOP,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW,9 LL,10 SC
//   addr_i          effective byte address
//   wdata_i         store data (rt)
//   flush_i         abandon the current op
//   llclr_i         clear the link bit
//   stall_req_o     pipeline stall request
//   done_o          one-cycle completion pulse, rdata_o/exc_o valid
//   rdata_o         load result, or SC success flag
//   exc_o           0 none, 1 AdEL, 2 AdES, 3 bus error
//   badvaddr_o      faulting address when exc_o != 0
//   llbit_o         current link bit
//   bus_*           req/ack data bus (word address, byte enables, lanes)
module mem_bus_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid_i,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              flush_i,
    input  logic              llclr_i,
    output logic              stall_req_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic [1:0]        exc_o,
    output logic [ADDR_W-1:0] badvaddr_o,
    output logic              llbit_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i,
    input  logic              bus_err_i
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [3:0] OP_LL  = 4'd9;
    localparam logic [3:0] OP_SC  = 4'd10;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_ADEL = 2'd1;
    localparam logic [1:0] EXC_ADES = 2'd2;
    localparam logic [1:0] EXC_BUS  = 2'd3;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t            state, next_state;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt;

    logic              is_load, is_store, is_half, is_word, misaligned;
    logic              launch, imm_exc, sc_fail, complete, bus_end;
    logic [3:0]        lane_sel;
    logic [31:0]       lane_wdata;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       load_data;

    // Classify the incoming op. Unknown encodings fall out as neither load
    // nor store, so they behave like NOP. Halfword ops need addr[0]=0.
    // Word ops, LL and SC need addr[1:0]=0.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (op_i)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
            OP_LW, OP_LL:  begin is_load = 1'b1; is_word = 1'b1; end
            OP_SB:         is_store = 1'b1;
            OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW, OP_SC:  begin is_store = 1'b1; is_word = 1'b1; end
            default:       ;
        endcase
        misaligned = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
    end

    // Byte-lane steering for stores. Narrow store data is replicated across
    // the lanes so that the slave only has to honour the byte enables.
    always_comb begin
        lane_sel   = 4'b1111;
        lane_wdata = wdata_i;
        case (op_i)
            OP_SB: begin
                lane_sel   = 4'b0001 << addr_i[1:0];
                lane_wdata = {4{wdata_i[7:0]}};
            end
            OP_SH: begin
                lane_sel   = addr_i[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the lane of the returning word that addr selects, then extend it.
    // A successful SC reports 1. Other stores return 0.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_byte = bus_rdata_i[7:0];
            2'd1:    lane_byte = bus_rdata_i[15:8];
            2'd2:    lane_byte = bus_rdata_i[23:16];
            default: lane_byte = bus_rdata_i[31:24];
        endcase
        lane_half = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (op_q)
            OP_LB:        load_data = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:       load_data = {24'd0, lane_byte};
            OP_LH:        load_data = {{16{lane_half[15]}}, lane_half};
            OP_LHU:       load_data = {16'd0, lane_half};
            OP_LW, OP_LL: load_data = bus_rdata_i;
            OP_SC:        load_data = 32'd1;
            default:      load_data = 32'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state logic and the control strobes for the datapath.
    // - A flush during WAIT leaves the bus request up until the slave
    //   finishes, which keeps the bus protocol intact.
    // - If the flush lands in the same cycle as the ack or the timeout, the
    //   unit returns straight to IDLE. It must not drain for an ack that will
    //   never come.
    // - The IDLE stall term is gated by rst so that every output reads 0
    //   while reset is held.
    always_comb begin
        next_state  = state;
        stall_req_o = 1'b0;
        done_o      = 1'b0;
        launch      = 1'b0;
        imm_exc     = 1'b0;
        sc_fail     = 1'b0;
        complete    = 1'b0;
        bus_end     = bus_ack_i || (cnt == TIMEOUT_CNT);
        case (state)
            IDLE: begin
                if (rst && op_valid_i && (is_load || is_store) && !flush_i) begin
                    stall_req_o = 1'b1;
                    if (misaligned) begin
                        imm_exc    = 1'b1;
                        next_state = DONE;
                    end else if ((op_i == OP_SC) && !llbit_o) begin
                        sc_fail    = 1'b1;
                        next_state = DONE;
                    end else begin
                        launch     = 1'b1;
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_req_o = 1'b1;
                if (bus_end) begin
                    complete   = !flush_i;
                    next_state = flush_i ? IDLE : DONE;
                end else if (flush_i) begin
                    next_state = DRAIN;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                next_state = IDLE;
            end
            DRAIN: begin
                if (bus_end) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Bus side. Address, lanes and strobe are captured when the access is
    // launched and stay put until the ack or the timeout. The timeout
    // counter saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= 4'b0000;
            bus_wdata_o <= 32'd0;
            cnt         <= '0;
            op_q        <= 4'd0;
            addr_q      <= '0;
        end else if (launch) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store;
            bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
            bus_sel_o   <= lane_sel;
            bus_wdata_o <= lane_wdata;
            cnt         <= '0;
            op_q        <= op_i;
            addr_q      <= addr_i;
        end else if ((state == WAIT) || (state == DRAIN)) begin
            if (bus_end) begin
                bus_req_o <= 1'b0;
                bus_we_o  <= 1'b0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // Result registers. They change only at an event that leads into DONE,
    // so they hold their value from one done_o pulse to the next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_o    <= 32'd0;
            exc_o      <= EXC_NONE;
            badvaddr_o <= '0;
        end else if (imm_exc) begin
            rdata_o    <= 32'd0;
            exc_o      <= is_store ? EXC_ADES : EXC_ADEL;
            badvaddr_o <= addr_i;
        end else if (sc_fail) begin
            rdata_o    <= 32'd0;
            exc_o      <= EXC_NONE;
            badvaddr_o <= '0;
        end else if (complete) begin
            if (bus_ack_i && !bus_err_i) begin
                rdata_o    <= load_data;
                exc_o      <= EXC_NONE;
                badvaddr_o <= '0;
            end else begin
                rdata_o    <= 32'd0;
                exc_o      <= EXC_BUS;
                badvaddr_o <= addr_q;
            end
        end
    end

    // Link bit. An explicit clear beats a same-cycle LL completion. Only a
    // clean bus completion may set or consume the link.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llbit_o <= 1'b0;
        end else if (llclr_i) begin
            llbit_o <= 1'b0;
        end else if (complete && bus_ack_i && !bus_err_i) begin
            if (op_q == OP_LL)      llbit_o <= 1'b1;
            else if (op_q == OP_SC) llbit_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_bus_unit.sv
// tb_mem_bus_unit
// Directed bench for mem_bus_unit. The unit is built with TIMEOUT=4 so that
// bus timeouts are short. The bench plays the bus slave inside runOp: it
// acks after a chosen number of wait states, or never. Expected values are
// worked out by hand from the address, the lane and the extension rules.
module tb_mem_bus_unit;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 8;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [3:0] OP_LL  = 4'd9;
    localparam logic [3:0] OP_SC  = 4'd10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              op_valid = 1'b0;
    logic [3:0]        op = 4'd0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = 32'd0;
    logic              flush = 1'b0;
    logic              llclr = 1'b0;
    logic              stall_req_o, done_o, llbit_o, bus_req_o, bus_we_o;
    logic [31:0]       rdata_o, bus_wdata_o;
    logic [1:0]        exc_o;
    logic [ADDR_W-1:0] badvaddr_o, bus_addr_o;
    logic [3:0]        bus_sel_o;
    logic              bus_ack = 1'b0;
    logic [31:0]       bus_rdata = 32'd0;
    logic              bus_err = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    int          lat;
    int          req_cycles;
    logic        saw_req;
    logic        stall_at_accept;
    logic        stall_at_done;
    logic [3:0]  cap_sel;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_we;

    mem_bus_unit #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid_i  (op_valid),
        .op_i        (op),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .flush_i     (flush),
        .llclr_i     (llclr),
        .stall_req_o (stall_req_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .exc_o       (exc_o),
        .badvaddr_o  (badvaddr_o),
        .llbit_o     (llbit_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack),
        .bus_rdata_i (bus_rdata),
        .bus_err_i   (bus_err)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op to the unit.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a,
                                 input logic [31:0] d);
        op_valid = 1'b1;
        op       = o;
        addr     = a;
        wdata    = d;
    endtask

    // Run one op to completion. Cycle 0 is the accept cycle. waits < 0
    // means the slave never acks. The task records the latency in cycles to
    // done_o, the number of cycles with bus_req high, and the bus fields on
    // the first request cycle. It returns in IDLE one cycle after done_o.
    task automatic runOp(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] d, input int waits,
                         input logic [31:0] rd, input logic err);
        applyStimulus(o, a, d);
        #1;
        stall_at_accept = stall_req_o;
        lat           = -1;
        req_cycles    = 0;
        saw_req       = 1'b0;
        stall_at_done = 1'b0;
        cap_sel       = 4'd0;
        cap_addr      = 32'd0;
        cap_wdata     = 32'd0;
        cap_we        = 1'b0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            tick();
            bus_ack   = 1'b0;
            bus_err   = 1'b0;
            bus_rdata = 32'd0;
            if (done_o) begin
                lat           = c;
                stall_at_done = stall_req_o;
                op_valid      = 1'b0;
            end else if (bus_req_o) begin
                if (!saw_req) begin
                    cap_sel   = bus_sel_o;
                    cap_addr  = bus_addr_o;
                    cap_wdata = bus_wdata_o;
                    cap_we    = bus_we_o;
                end
                saw_req = 1'b1;
                req_cycles++;
                if (waits >= 0 && req_cycles == waits + 1) begin
                    bus_ack   = 1'b1;
                    bus_err   = err;
                    bus_rdata = rd;
                end
            end
        end
        if (lat < 0) begin
            checkOutput("done_within_bound", 32'(done_o), 32'd1);
            op_valid = 1'b0;
        end
        tick();
    endtask

    initial begin
        // Reset state.
        repeat (3) tick();
        checkOutput("rst_stall", 32'(stall_req_o), 32'd0);
        checkOutput("rst_done", 32'(done_o), 32'd0);
        checkOutput("rst_req", 32'(bus_req_o), 32'd0);
        checkOutput("rst_llbit", 32'(llbit_o), 32'd0);
        checkOutput("rst_exc", 32'(exc_o), 32'd0);
        rst = 1'b1;
        tick();

        // LB from lane 3 with two wait states. Done comes 3 cycles after the
        // request opens (request in cycle 1, done in cycle 4).
        runOp(OP_LB, 32'h0000_0103, 32'd0, 2, 32'h80FF_1234, 1'b0);
        checkOutput("lb_stall_accept", 32'(stall_at_accept), 32'd1);
        checkOutput("lb_sel", 32'(cap_sel), 32'h0000_000F);
        checkOutput("lb_addr", cap_addr, 32'h0000_0100);
        checkOutput("lb_we", 32'(cap_we), 32'd0);
        checkOutput("lb_latency", 32'(lat), 32'd4);
        checkOutput("lb_rdata", rdata_o, 32'hFFFF_FF80);
        checkOutput("lb_exc", 32'(exc_o), 32'd0);

        runOp(OP_LBU, 32'h0000_0103, 32'd0, 2, 32'h80FF_1234, 1'b0);
        checkOutput("lbu_rdata", rdata_o, 32'h0000_0080);

        runOp(OP_LH, 32'h0000_0102, 32'd0, 0, 32'h80FF_1234, 1'b0);
        checkOutput("lh_rdata", rdata_o, 32'hFFFF_80FF);
        runOp(OP_LHU, 32'h0000_0100, 32'd0, 1, 32'h80FF_9234, 1'b0);
        checkOutput("lhu_rdata", rdata_o, 32'h0000_9234);

        // SH into the upper half, acked in the first cycle.
        runOp(OP_SH, 32'h0000_0202, 32'h0000_ABCD, 0, 32'd0, 1'b0);
        checkOutput("sh_addr", cap_addr, 32'h0000_0200);
        checkOutput("sh_sel", 32'(cap_sel), 32'h0000_000C);
        checkOutput("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        checkOutput("sh_we", 32'(cap_we), 32'd1);
        checkOutput("sh_latency", 32'(lat), 32'd2);

        runOp(OP_SB, 32'h0000_0201, 32'h1234_5678, 0, 32'd0, 1'b0);
        checkOutput("sb_sel", 32'(cap_sel), 32'h0000_0002);
        checkOutput("sb_wdata", cap_wdata, 32'h7878_7878);

        // Misaligned accesses never reach the bus.
        runOp(OP_LW, 32'h0000_0101, 32'd0, 0, 32'd0, 1'b0);
        checkOutput("adel_no_req", 32'(saw_req), 32'd0);
        checkOutput("adel_latency", 32'(lat), 32'd1);
        checkOutput("adel_exc", 32'(exc_o), 32'd1);
        checkOutput("adel_badvaddr", badvaddr_o, 32'h0000_0101);
        runOp(OP_SW, 32'h0000_0102, 32'h5555_AAAA, 0, 32'd0, 1'b0);
        checkOutput("ades_exc", 32'(exc_o), 32'd2);
        checkOutput("ades_badvaddr", badvaddr_o, 32'h0000_0102);

        // No ack: the request stays up for TIMEOUT+1 cycles, then a bus error.
        runOp(OP_LW, 32'h0000_0500, 32'd0, -1, 32'd0, 1'b0);
        checkOutput("to_req_cycles", 32'(req_cycles), 32'd5);
        checkOutput("to_latency", 32'(lat), 32'd6);
        checkOutput("to_exc", 32'(exc_o), 32'd3);
        checkOutput("to_badvaddr", badvaddr_o, 32'h0000_0500);
        checkOutput("to_stall_done", 32'(stall_at_done), 32'd0);
        checkOutput("to_req_after", 32'(bus_req_o), 32'd0);

        // Ack with the error flag set.
        runOp(OP_LW, 32'h0000_0600, 32'd0, 1, 32'h1234_5678, 1'b1);
        checkOutput("berr_exc", 32'(exc_o), 32'd3);
        checkOutput("berr_rdata", rdata_o, 32'd0);

        // LL, then a successful SC, then an SC that fails.
        runOp(OP_LL, 32'h0000_0040, 32'd0, 0, 32'hDEAD_BEEF, 1'b0);
        checkOutput("ll_rdata", rdata_o, 32'hDEAD_BEEF);
        checkOutput("ll_llbit", 32'(llbit_o), 32'd1);
        runOp(OP_SC, 32'h0000_0040, 32'h0000_0055, 0, 32'd0, 1'b0);
        checkOutput("sc_req", 32'(saw_req), 32'd1);
        checkOutput("sc_we", 32'(cap_we), 32'd1);
        checkOutput("sc_sel", 32'(cap_sel), 32'h0000_000F);
        checkOutput("sc_rdata", rdata_o, 32'd1);
        checkOutput("sc_llbit", 32'(llbit_o), 32'd0);
        runOp(OP_SC, 32'h0000_0040, 32'h0000_0055, 0, 32'd0, 1'b0);
        checkOutput("sc2_no_req", 32'(saw_req), 32'd0);
        checkOutput("sc2_latency", 32'(lat), 32'd1);
        checkOutput("sc2_rdata", rdata_o, 32'd0);

        // LL, then llclr: the next SC fails without a bus cycle.
        runOp(OP_LL, 32'h0000_0040, 32'd0, 0, 32'h0000_0001, 1'b0);
        llclr = 1'b1;
        tick();
        llclr = 1'b0;
        checkOutput("llclr_llbit", 32'(llbit_o), 32'd0);
        runOp(OP_SC, 32'h0000_0040, 32'h0000_0077, 0, 32'd0, 1'b0);
        checkOutput("llclr_sc_no_req", 32'(saw_req), 32'd0);
        checkOutput("llclr_sc_rdata", rdata_o, 32'd0);

        // Flush of an LL during WAIT: drain until ack, no done, no link.
        applyStimulus(OP_LL, 32'h0000_0048, 32'd0);
        tick();
        checkOutput("flush_req_start", 32'(bus_req_o), 32'd1);
        flush    = 1'b1;
        op_valid = 1'b0;
        tick();
        flush = 1'b0;
        checkOutput("flush_drain_req", 32'(bus_req_o), 32'd1);
        checkOutput("flush_drain_stall", 32'(stall_req_o), 32'd0);
        checkOutput("flush_drain_done", 32'(done_o), 32'd0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_1111;
        tick();
        bus_ack = 1'b0;
        checkOutput("flush_req_drop", 32'(bus_req_o), 32'd0);
        checkOutput("flush_no_done", 32'(done_o), 32'd0);
        tick();
        checkOutput("flush_no_done2", 32'(done_o), 32'd0);
        checkOutput("flush_llbit", 32'(llbit_o), 32'd0);

        // Reset while a request is outstanding, after LL has set the link.
        runOp(OP_LL, 32'h0000_0040, 32'd0, 0, 32'hCAFE_0001, 1'b0);
        applyStimulus(OP_LW, 32'h0000_0400, 32'd0);
        tick();
        checkOutput("mid_req_before", 32'(bus_req_o), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_req", 32'(bus_req_o), 32'd0);
        checkOutput("mid_rst_stall", 32'(stall_req_o), 32'd0);
        checkOutput("mid_rst_llbit", 32'(llbit_o), 32'd0);
        checkOutput("mid_rst_rdata", rdata_o, 32'd0);
        checkOutput("mid_rst_sel", 32'(bus_sel_o), 32'd0);
        op_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checkOutput("post_rst_done", 32'(done_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_bus_unit.md
Name: mem_bus_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle MEM data path.
- Accepts one load/store per request from the MEM stage and runs it on a req/ack data bus with wait states and timeout. Performs byte-lane steering and sign/zero extension, alignment and bus-error detection, and LL/SC link tracking.
- Raises stall_req_o to freeze the pipeline until the access completes.

Parameters:
- ADDR_W, 32, byte-address width of addr_i / bus_addr_o.
- TIMEOUT, 255, max cycles bus_req_o stays high without bus_ack_i before a bus error is declared (≥1).
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- op_valid_i  in  1  memory op present; inputs held stable while stall_req_o=1.
- op_i  in  4  encoding: 0 NOP, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; others are treated as NOP.
- addr_i  in  ADDR_W  effective address.
- wdata_i  in  32  store data (rt).
- flush_i  in  1  pipeline flush (exception/eret); abandons the current op.
- llclr_i  in  1  clear link bit (eret).
- stall_req_o  out  1  pipeline stall request.
- done_o  out  1  one-cycle pulse: op complete, rdata_o/exc_o valid.
- rdata_o  out  32  load result; SC result 1/0.
- exc_o  out  2  0 none, 1 AdEL, 2 AdES, 3 bus error.
- badvaddr_o  out  ADDR_W  faulting address when exc_o≠0.
- llbit_o  out  1  current link bit.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  write strobe.
- bus_addr_o  out  ADDR_W  word-aligned address, low 2 bits 0.
- bus_sel_o  out  4  byte enables; bit n covers bits [8n+7:8n].
- bus_wdata_o  out  32  store data, replicated into lanes.
- bus_ack_i  in  1  transfer complete; bus_rdata_i is valid in the same cycle.
- bus_rdata_i  in  32  read data.
- bus_err_i  in  1  bus error; only sampled when bus_ack_i=1.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all outputs 0, llbit 0, counter 0.
- FSM states: IDLE, WAIT, DONE, DRAIN.
- IDLE, op_valid_i=1 and op not NOP:
  - Misaligned address → DONE with AdEL (loads/LL) or AdES (stores/SC), no bus cycle. Halfword requires addr[0]=0; word, LL and SC require addr[1:0]=0.
  - SC with llbit=0 → DONE, rdata 0, no bus cycle.
  - Otherwise → WAIT. Bus outputs are registered at the transition, counter cleared.
- IDLE with op NOP or op_valid_i=0: nothing happens, stall_req_o=0.
- stall_req_o is combinational: 1 in IDLE when a non-NOP op is valid and flush_i=0, 1 in WAIT, 0 in DONE and DRAIN.
- WAIT: bus_req_o held with stable addr/sel/we/wdata.
  - On bus_ack_i → DONE. Loads extend the selected lane; if bus_err_i=1 then exc 3.
  - On counter==TIMEOUT without ack → DONE with exc 3, bus_req_o dropped.
  - Counter saturates and never wraps.
- DONE: done_o=1 for exactly one cycle, then IDLE.
  - Minimum latency with ack in the first WAIT cycle: accept N, req N+1, ack N+1, done N+2.
  - rdata_o and exc_o hold their values until the next done_o.
- Lane rules:
  - SB: sel = 1<<addr[1:0], wdata = {4{rt[7:0]}}.
  - SH: sel 0011 or 1100, wdata = {2{rt[15:0]}}.
  - SW/SC: sel 1111.
  - Loads drive sel 1111. LB/LH sign-extend; LBU/LHU zero-extend the lane selected by addr[1:0].
- LL/SC:
  - LL done without exc sets llbit.
  - SC done with a write performed (no exc) clears llbit and returns rdata 1.
  - An SC that fails or bus-errors returns rdata 0.
  - llclr_i clears llbit and has priority over a same-cycle LL set.
- flush_i:
  - In IDLE: the op is ignored.
  - In WAIT: go to DRAIN. bus_req_o stays high until ack or timeout, then IDLE with no done_o and no llbit update.
  - In DONE: done_o is still pulsed; the consumer discards it.
- Reset mid-transaction: bus_req_o drops immediately, state IDLE.

Test Plan:
- LB at addr 0x103, bus_rdata 0x80FF_1234 with 2 wait states → bus_sel_o 1111, done_o 3 cycles after the ack window opens, rdata_o 0xFFFF_FF80, exc 0; LBU of the same access gives 0x0000_0080.
- SH rt=0x0000_ABCD at 0x202, ack first cycle → bus_addr_o 0x200, bus_sel_o 1100, bus_wdata_o 0xABCD_ABCD, bus_we_o 1, done_o at N+2.
- LW at 0x101 → no bus_req_o, done_o next cycle, exc_o 1, badvaddr_o 0x101; SW at 0x102 gives exc_o 2.
- No ack with TIMEOUT=4 → bus_req_o high 5 cycles, then done_o with exc_o 3, stall_req_o low.
- LL 0x40, then SC 0x40 → llbit_o 1, then SC write with rdata_o 1 and llbit_o 0. A second SC returns rdata 0 with no bus_req_o. LL followed by llclr_i makes the next SC fail.
- flush_i during WAIT → bus_req_o held until ack, then no done_o, llbit unchanged. rst low during WAIT → all outputs 0 asynchronously.
